// File: rtl/step_sequencer_tone_gen.sv
// ----------------------------------------------------------------------------
// step_sequencer_tone_gen
//   Step sequencer core for the audio sample path. Walks a STEPS-long on/off
//   pattern at a fixed tempo. On every active step it emits a gated square
//   wave as signed stereo samples over a valid/ready handshake.
//
// Ports
//   CLOCK_50      in   system clock
//   resetn        in   async active-low reset
//   load_n        in   raw active-low load button (asynchronous)
//   pattern_in    in   pattern source, captured on a load_n press
//   run           in   1 = sequencer advances, 0 = hold and silence
//   sample_ready  in   consumer accepts a sample this cycle
//   sample_valid  out  sample outputs hold a valid sample
//   sample_left   out  signed left sample
//   sample_right  out  signed right sample (identical to left)
//   step_idx      out  current step
//   pattern       out  loaded pattern register
// ----------------------------------------------------------------------------
module step_sequencer_tone_gen #(
    parameter int unsigned STEPS        = 8,
    parameter int unsigned TEMPO_CYCLES = 6250000,
    parameter int unsigned GATE_CYCLES  = 3125000,
    parameter int unsigned HALF_PERIOD  = 56818,
    parameter int unsigned DW           = 24,
    parameter logic [DW-1:0] AMPLITUDE  = DW'(24'h100000),
    localparam int unsigned SIW         = (STEPS > 1) ? $clog2(STEPS) : 1
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              load_n,
    input  logic [STEPS-1:0]  pattern_in,
    input  logic              run,
    input  logic              sample_ready,
    output logic              sample_valid,
    output logic [DW-1:0]     sample_left,
    output logic [DW-1:0]     sample_right,
    output logic [SIW-1:0]    step_idx,
    output logic [STEPS-1:0]  pattern
);

    localparam int unsigned TW = (TEMPO_CYCLES > 1) ? $clog2(TEMPO_CYCLES) : 1;
    localparam int unsigned GW = $clog2(GATE_CYCLES + 1) > 0 ? $clog2(GATE_CYCLES + 1) : 1;
    localparam int unsigned HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    localparam logic [TW-1:0]  TEMPO_LAST = TW'(TEMPO_CYCLES - 1);
    localparam logic [GW-1:0]  GATE_LIM   = GW'(GATE_CYCLES);
    localparam logic [HW-1:0]  HALF_LAST  = HW'(HALF_PERIOD - 1);
    localparam logic [SIW-1:0] STEP_LAST  = SIW'(STEPS - 1);
    localparam logic [DW-1:0]  NEG_AMP    = (~AMPLITUDE) + DW'(1);

    // load button synchroniser (s1, s2) plus edge-detect history (s3)
    logic load_s1_q, load_s2_q, load_s3_q;

    logic [STEPS-1:0] pattern_q,  pattern_d;
    logic [SIW-1:0]   step_q,     step_d;
    logic [TW-1:0]    tempo_q,    tempo_d;
    logic [GW-1:0]    gate_q,     gate_d;
    logic [HW-1:0]    half_q,     half_d;
    logic             phase_q,    phase_d;
    logic             valid_q,    valid_d;
    logic [DW-1:0]    sample_q,   sample_d;

    logic             load_fall;
    logic             boundary;
    logic             active;
    logic [DW-1:0]    next_sample;

    // Next-state logic for pattern, tempo, tone and handshake
    always_comb begin
        pattern_d   = pattern_q;
        step_d      = step_q;
        tempo_d     = tempo_q;
        gate_d      = gate_q;
        half_d      = half_q;
        phase_d     = phase_q;
        valid_d     = 1'b1;
        sample_d    = sample_q;

        load_fall   = load_s3_q & ~load_s2_q;
        boundary    = run & (tempo_q == TEMPO_LAST);
        active      = run & pattern_q[step_q] & (gate_q < GATE_LIM);
        next_sample = '0;
        if (active) begin
            next_sample = phase_q ? AMPLITUDE : NEG_AMP;
        end

        if (load_fall) begin
            pattern_d = pattern_in;
        end

        if (run) begin
            if (boundary) begin
                tempo_d = '0;
                gate_d  = '0;
                step_d  = (step_q == STEP_LAST) ? '0 : step_q + SIW'(1);
            end else begin
                tempo_d = tempo_q + TW'(1);
                if (gate_q < GATE_LIM) begin
                    gate_d = gate_q + GW'(1);
                end
            end
        end

        // A step boundary overrides any tone toggle on the same edge
        if (boundary || !active) begin
            half_d  = '0;
            phase_d = 1'b0;
        end else if (half_q == HALF_LAST) begin
            half_d  = '0;
            phase_d = ~phase_q;
        end else begin
            half_d  = half_q + HW'(1);
        end

        if (valid_q && sample_ready) begin
            sample_d = next_sample;
        end
    end

    // State registers
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            load_s1_q <= 1'b1;
            load_s2_q <= 1'b1;
            load_s3_q <= 1'b1;
            pattern_q <= '0;
            step_q    <= '0;
            tempo_q   <= '0;
            gate_q    <= '0;
            half_q    <= '0;
            phase_q   <= 1'b0;
            valid_q   <= 1'b0;
            sample_q  <= '0;
        end else begin
            load_s1_q <= load_n;
            load_s2_q <= load_s1_q;
            load_s3_q <= load_s2_q;
            pattern_q <= pattern_d;
            step_q    <= step_d;
            tempo_q   <= tempo_d;
            gate_q    <= gate_d;
            half_q    <= half_d;
            phase_q   <= phase_d;
            valid_q   <= valid_d;
            sample_q  <= sample_d;
        end
    end

    assign sample_valid = valid_q;
    assign sample_left  = sample_q;
    assign sample_right = sample_q;
    assign step_idx     = step_q;
    assign pattern      = pattern_q;

endmodule

// File: tb/tb_step_sequencer_tone_gen.sv
// ----------------------------------------------------------------------------
// tb_step_sequencer_tone_gen
//   Self-checking bench for step_sequencer_tone_gen with short tempo values.
//   A behavioural model predicts each sample; predictions are queued before
//   each clock edge and compared against the DUT after it.
// ----------------------------------------------------------------------------
module tb_step_sequencer_tone_gen;

    localparam int unsigned STEPS = 8;
    localparam int unsigned TEMPO = 20;
    localparam int unsigned GATE  = 10;
    localparam int unsigned HALF  = 3;
    localparam int unsigned DW    = 24;
    localparam logic [DW-1:0] AMP     = 24'h100000;
    localparam logic [DW-1:0] NEG_AMP = 24'hF00000;

    logic              clk;
    logic              resetn;
    logic              load_n;
    logic [STEPS-1:0]  pattern_in;
    logic              run;
    logic              sample_ready;
    logic              sample_valid;
    logic [DW-1:0]     sample_left;
    logic [DW-1:0]     sample_right;
    logic [2:0]        step_idx;
    logic [STEPS-1:0]  pattern;

    step_sequencer_tone_gen #(
        .STEPS        (STEPS),
        .TEMPO_CYCLES (TEMPO),
        .GATE_CYCLES  (GATE),
        .HALF_PERIOD  (HALF),
        .DW           (DW),
        .AMPLITUDE    (AMP)
    ) dut (
        .CLOCK_50     (clk),
        .resetn       (resetn),
        .load_n       (load_n),
        .pattern_in   (pattern_in),
        .run          (run),
        .sample_ready (sample_ready),
        .sample_valid (sample_valid),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .step_idx     (step_idx),
        .pattern      (pattern)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Behavioural model: tone age counts consecutive active cycles in a step
    int unsigned      m_tempo, m_step, m_gate, m_age;
    logic             m_valid;
    logic [DW-1:0]    m_samp;
    logic [STEPS-1:0] m_pat;
    logic [DW-1:0]    sb_q[$];

    task automatic model_reset();
        m_tempo = 0; m_step = 0; m_gate = 0; m_age = 0;
        m_valid = 1'b0; m_samp = '0; m_pat = '0;
        sb_q.delete();
    endtask

    // One clock: predict, advance the model, compare after the edge
    task automatic cycle();
        logic          act;
        logic          ph;
        logic [DW-1:0] nxt;
        logic [DW-1:0] exp_s;
        act = run && m_pat[m_step] && (m_gate < GATE);
        ph  = ((m_age / HALF) % 2) == 1;
        nxt = act ? (ph ? AMP : NEG_AMP) : '0;
        if (m_valid && sample_ready) m_samp = nxt;
        sb_q.push_back(m_samp);
        m_valid = 1'b1;
        if (run) begin
            if (m_tempo == TEMPO - 1) begin
                m_tempo = 0; m_gate = 0; m_age = 0;
                m_step  = (m_step + 1) % STEPS;
            end else begin
                m_tempo++;
                if (m_gate < GATE) m_gate++;
                m_age = act ? m_age + 1 : 0;
            end
        end else begin
            m_age = 0;
        end
        @(posedge clk);
        #1;
        exp_s = sb_q.pop_front();
        check("sample_left",  32'(sample_left),  32'(exp_s));
        check("sample_right", 32'(sample_right), 32'(exp_s));
        check("valid",        32'(sample_valid), 32'(m_valid));
        check("step_idx",     32'(step_idx),     m_step);
    endtask

    initial begin
        bit found;
        model_reset();
        resetn       = 1'b0;
        load_n       = 1'b1;
        pattern_in   = '0;
        run          = 1'b0;
        sample_ready = 1'b1;

        // Reset state
        #12;
        check("rst_valid",   32'(sample_valid), 0);
        check("rst_sample",  32'(sample_left),  0);
        check("rst_step",    32'(step_idx),     0);
        check("rst_pattern", 32'(pattern),      0);
        resetn = 1'b1;
        cycle();
        check("valid_after_release", 32'(sample_valid), 1);

        // Load through the synchroniser
        pattern_in = 8'h83;
        load_n     = 1'b0;
        cycle();
        load_n     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            if (pattern == 8'h83) break;
        end
        check("load_latency", 32'(pattern), 32'h83);
        m_pat      = 8'h83;
        pattern_in = 8'h00;
        repeat (6) cycle();
        check("load_hold", 32'(pattern), 32'h83);

        // Run a full pattern cycle
        run = 1'b1;
        repeat (20) cycle();
        check("step_at_20", 32'(step_idx), 1);
        repeat (140) cycle();
        check("step_wrap_160", 32'(step_idx), 0);

        // Back-pressure during a tone
        repeat (4) cycle();
        sample_ready = 1'b0;
        repeat (50) cycle();
        check("hold_value", 32'(sample_left), 32'(AMP));
        check("hold_valid", 32'(sample_valid), 1);
        sample_ready = 1'b1;
        repeat (5) cycle();

        // Pause at cycle 5 of step 1
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_step == 1 && m_tempo == 5) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        check("reach_step1_t5", 32'(found), 1);
        run = 1'b0;
        repeat (30) cycle();
        check("pause_step", 32'(step_idx), 1);
        check("pause_silent", 32'(sample_left), 0);
        run = 1'b1;
        repeat (14) cycle();
        check("resume_step_14", 32'(step_idx), 1);
        cycle();
        check("resume_step_15", 32'(step_idx), 2);

        // Async reset mid-tone of step 0
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_step == 0 && m_tempo == 4) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        check("reach_step0_t4", 32'(found), 1);
        check("midtone_sample", 32'(sample_left), 32'(AMP));
        #2;
        resetn = 1'b0;
        #1;
        check("arst_left",    32'(sample_left),  0);
        check("arst_right",   32'(sample_right), 0);
        check("arst_step",    32'(step_idx),     0);
        check("arst_pattern", 32'(pattern),      0);
        check("arst_valid",   32'(sample_valid), 0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        run    = 1'b0;
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
